cpu_pipe_param: RTL

Parametrised three-stage (fetch / decode / execute) pipelined microcontroller core, next generation of the stage-3 LED CPU. Adds a configurable datapath width, program depth and register file, a host program-load port, load-immediate, subtract, conditional branch and halt. Sits directly under the Tiny Tapeout top, which drives `led` onto a user output bus.

---
 rtl/cpu_pipe_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_pipe_param.sv
// cpu_pipe_param: parametrised fetch/decode/execute microcontroller core with a
// host program-load port, load-immediate, add/sub, branches, DELAY stall and HALT.
module cpu_pipe_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_data,
  output logic [DATA_W-1:0] led,
  output logic              halted,
  output logic              retired
);

  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned DEPTH  = 1 << PC_W;

  typedef struct packed {
    logic halt;
    logic subi;
    logic bnz;
    logic ldi;
    logic delay;
    logic out;
    logic jmp;
    logic addi;
  } op_flags_t;

  typedef struct packed {
    logic [7:0]        imm;
    logic [RIDX_W-1:0] rd;
    logic [PC_W-1:0]   pc;
    op_flags_t         op;
  } slot_t;

  function automatic op_flags_t decode_op(input logic [3:0] opc);
    op_flags_t f;
    f = '0;
    case (opc)
      4'd1:    f.addi  = 1'b1;
      4'd2:    f.jmp   = 1'b1;
      4'd3:    f.out   = 1'b1;
      4'd4:    f.delay = 1'b1;
      4'd5:    f.ldi   = 1'b1;
      4'd6:    f.bnz   = 1'b1;
      4'd7:    f.subi  = 1'b1;
      4'd8:    f.halt  = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  logic [15:0]       mem [DEPTH];
  logic [DATA_W-1:0] regs [NREGS];
  logic [PC_W-1:0]   pc;
  logic              dec_valid;
  slot_t             dec_slot;
  logic              ex_valid;
  slot_t             ex_slot;
  logic [7:0]        dly_cnt;

  slot_t             fetch_slot_c;
  logic [DATA_W-1:0] rd_val_c;
  logic [DATA_W-1:0] imm_d_c;
  logic [PC_W-1:0]   target_c;
  logic              ex_busy_c;
  logic              ex_done_c;
  logic              taken_c;
  logic              halt_now_c;
  logic              flush_c;
  logic              dec_ready_c;
  logic              fetch_fire_c;

  // Host program port; no reset so the program survives a core reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Fetch: combinational read of the word at pc.
  always_comb begin
    fetch_slot_c     = '0;
    fetch_slot_c.imm = mem[pc][15:8];
    fetch_slot_c.rd  = mem[pc][4 +: RIDX_W];
    fetch_slot_c.pc  = pc;
    fetch_slot_c.op  = decode_op(mem[pc][3:0]);
  end

  // Execute-stage control: DELAY stall, branch resolution and flush.
  always_comb begin
    rd_val_c     = regs[ex_slot.rd];
    imm_d_c      = DATA_W'(ex_slot.imm);
    target_c     = PC_W'(ex_slot.imm);
    ex_busy_c    = ex_valid && ex_slot.op.delay && (dly_cnt != ex_slot.imm);
    ex_done_c    = ex_valid && !ex_busy_c;
    taken_c      = ex_done_c && (ex_slot.op.jmp || (ex_slot.op.bnz && (rd_val_c != '0)));
    halt_now_c   = ex_done_c && ex_slot.op.halt;
    flush_c      = taken_c || halt_now_c;
    dec_ready_c  = !dec_valid || !ex_busy_c;
    fetch_fire_c = !halted && !flush_c && dec_ready_c;
  end

  // Pipeline registers and pc; a flush from execute overrides the fetch increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      dec_valid <= 1'b0;
      dec_slot  <= '0;
      ex_valid  <= 1'b0;
      ex_slot   <= '0;
      halted    <= 1'b0;
    end else if (flush_c) begin
      dec_valid <= 1'b0;
      ex_valid  <= 1'b0;
      if (taken_c) begin
        pc <= target_c;
      end else begin
        pc     <= ex_slot.pc + PC_W'(1);
        halted <= 1'b1;
      end
    end else begin
      if (!ex_busy_c) begin
        ex_valid <= dec_valid;
        ex_slot  <= dec_slot;
      end
      if (fetch_fire_c) begin
        dec_valid <= 1'b1;
        dec_slot  <= fetch_slot_c;
        pc        <= pc + PC_W'(1);
      end else if (!ex_busy_c) begin
        dec_valid <= 1'b0;
      end
    end
  end

  // Register file, led, delay counter and retire pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[RIDX_W'(i)] <= '0;
      end
      led     <= '0;
      retired <= 1'b0;
      dly_cnt <= 8'd0;
    end else begin
      retired <= ex_done_c;
      if (ex_valid && ex_slot.op.delay) begin
        dly_cnt <= ex_busy_c ? dly_cnt + 8'd1 : 8'd0;
      end
      if (ex_done_c) begin
        if (ex_slot.op.addi) regs[ex_slot.rd] <= rd_val_c + imm_d_c;
        if (ex_slot.op.subi) regs[ex_slot.rd] <= rd_val_c - imm_d_c;
        if (ex_slot.op.ldi)  regs[ex_slot.rd] <= imm_d_c;
        if (ex_slot.op.out)  led <= rd_val_c;
      end
    end
  end

endmodule
